// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision constants and the scheduler's in-flight tag type.
package fp_pkg;
    localparam int N     = 32;
    localparam int E     = 8;
    localparam int MA    = 23;
    localparam int P     = 24;
    localparam int BIAS  = 127;
    localparam int SIGN  = 31;
    localparam int EXP_H = 30;
    localparam int EXP_L = 23;
    localparam int M_H   = 22;
    localparam int M_L   = 0;
    localparam int IDW   = 2;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/fp_mul_rr_sched_if.sv
// fp_mul_rr_sched_if: requester handshakes, multiplier operand/result bus and tagged response bus.
interface fp_mul_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int N    = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_approx;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_approx;
    logic [N-1:0]      mul_y;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_y;
    logic              busy;

    modport master (
        output req_valid, req_approx, req_a, req_b, mul_y,
        input  req_ready, mul_a, mul_b, mul_approx, rsp_valid, rsp_id, rsp_y, busy
    );

    modport slave (
        input  req_valid, req_approx, req_a, req_b, mul_y,
        output req_ready, mul_a, mul_b, mul_approx, rsp_valid, rsp_id, rsp_y, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority grant, searching ptr_i, ptr_i+1, ... mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                any_o = 1'b1;
                idx_o = IDW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

    assign gnt_o = any_o ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : '0;
endmodule

// File: rtl/fp_mul_rr_sched.sv
// fp_mul_rr_sched: round-robin sharing of one fixed-latency FP multiplier among NREQ requesters,
// with an in-order tag pipeline that steers each product back to its requester.
module fp_mul_rr_sched import fp_pkg::*; #(
    parameter int NREQ = 4,
    parameter int N    = 32,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    fp_mul_rr_sched_if.slave    sch
);
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            any;
    logic            accept;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]    mul_a_q, mul_b_q, rsp_y_q;
    logic            mul_approx_q, rsp_valid_q, busy_q, busy_d;
    logic [IDW-1:0]  rsp_id_q;
    tag_t            tag_q [LAT+1];
    tag_t            tag_d [LAT+1];

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (sch.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (any)
    );

    assign accept        = any && !rst;
    assign sch.req_ready = rst ? '0 : gnt;
    assign ptr_d         = !accept ? ptr_q : (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;

    // The last tag stage lines up with mul_y, which trails the operand registers by LAT cycles.
    always_comb begin
        tag_d[0] = '{valid: accept, id: gidx};
        for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
        busy_d = tag_q[LAT].valid;
        for (int i = 0; i <= LAT; i++) busy_d = busy_d | tag_d[i].valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_approx_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_y_q      <= '0;
            busy_q       <= 1'b0;
            for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                mul_a_q      <= sch.req_a[gidx*N +: N];
                mul_b_q      <= sch.req_b[gidx*N +: N];
                mul_approx_q <= sch.req_approx[gidx];
            end
            tag_q       <= tag_d;
            rsp_valid_q <= tag_q[LAT].valid;
            rsp_id_q    <= tag_q[LAT].id;
            if (tag_q[LAT].valid) rsp_y_q <= sch.mul_y;
            busy_q      <= busy_d;
        end
    end

    assign sch.mul_a      = mul_a_q;
    assign sch.mul_b      = mul_b_q;
    assign sch.mul_approx = mul_approx_q;
    assign sch.rsp_valid  = rsp_valid_q;
    assign sch.rsp_id     = rsp_id_q;
    assign sch.rsp_y      = rsp_y_q;
    assign sch.busy       = busy_q;
endmodule
